// File: rtl/uart_slot_router.sv
// Routes the MCU's single UART pair to one of NUM_SLOTS card slots, switching
// only after the lines have drained idle and then been parked idle for a guard time.
module uart_slot_router #(
    parameter int UART_ADDRESS_WIDTH = 4,
    parameter int NUM_SLOTS          = 8,
    parameter int SYNC_STAGES        = 2,
    parameter int GUARD_CYCLES       = 1042,
    parameter int DRAIN_TIMEOUT      = 65535
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [UART_ADDRESS_WIDTH-1:0] uart_slot_en,
    input  logic                          mcu_tx,
    output logic                          mcu_rx,
    input  logic [NUM_SLOTS-1:0]          slot_rx,
    output logic [NUM_SLOTS-1:0]          slot_tx,
    output logic [UART_ADDRESS_WIDTH-1:0] active_slot,
    output logic                          switching,
    output logic                          drain_timeout
);

    typedef enum logic [1:0] {ROUTE, DRAIN, PARK} state_t;

    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);
    localparam logic [15:0] TMO_LAST   = 16'(DRAIN_TIMEOUT - 1);

    state_t                                  state, state_d;
    logic [UART_ADDRESS_WIDTH-1:0]           pending, pending_d, active_d;
    logic [15:0]                             idle_cnt, idle_cnt_d;
    logic [15:0]                             tmo_cnt, tmo_cnt_d;
    logic                                    timeout_d;

    logic [SYNC_STAGES-1:0]                  tx_sync;
    logic [SYNC_STAGES-1:0][NUM_SLOTS-1:0]   rx_sync;
    logic                                    tx_s;
    logic [NUM_SLOTS-1:0]                    rx_s;
    logic                                    sel_rx;
    logic                                    lines_idle;
    logic [NUM_SLOTS-1:0]                    slot_tx_d;
    logic                                    mcu_rx_d;

    // Idle-high reset so a freshly reset synchroniser never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_sync <= '1;
            rx_sync <= '1;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous
            // stage's old value, so the chain really is SYNC_STAGES flops deep.
            tx_sync <= {tx_sync[SYNC_STAGES-2:0], mcu_tx};
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], slot_rx};
        end
    end

    assign tx_s = tx_sync[SYNC_STAGES-1];
    assign rx_s = rx_sync[SYNC_STAGES-1];

    // Routing mux: an out-of-range active slot matches no index and stays idle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the loop/branches can leave it unassigned and infer a latch.
        sel_rx    = 1'b1;
        slot_tx_d = '1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (active_slot == UART_ADDRESS_WIDTH'(i)) begin
                sel_rx = rx_s[i];
                if (state != PARK) slot_tx_d[i] = tx_s;
            end
        end
        mcu_rx_d   = (state == PARK) ? 1'b1 : sel_rx;
        lines_idle = tx_s & sel_rx;
    end

    always_comb begin
        state_d    = state;
        pending_d  = pending;
        active_d   = active_slot;
        idle_cnt_d = idle_cnt;
        tmo_cnt_d  = tmo_cnt;
        timeout_d  = 1'b0;
        case (state)
            ROUTE: begin
                if (uart_slot_en != active_slot) begin
                    pending_d  = uart_slot_en;
                    idle_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                pending_d = uart_slot_en;
                tmo_cnt_d = tmo_cnt + 16'd1;
                if (uart_slot_en == active_slot) begin
                    state_d = ROUTE;
                end else if (lines_idle && idle_cnt == GUARD_LAST) begin
                    // Idle window completing wins over a simultaneous timeout.
                    state_d    = PARK;
                    idle_cnt_d = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d    = PARK;
                    idle_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    idle_cnt_d = lines_idle ? idle_cnt + 16'd1 : '0;
                end
            end
            PARK: begin
                if (idle_cnt == GUARD_LAST) begin
                    active_d   = pending;
                    idle_cnt_d = '0;
                    state_d    = ROUTE;
                end else begin
                    idle_cnt_d = idle_cnt + 16'd1;
                end
            end
            default: state_d = ROUTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ROUTE;
            active_slot   <= '0;
            pending       <= '0;
            idle_cnt      <= '0;
            tmo_cnt       <= '0;
            switching     <= 1'b0;
            drain_timeout <= 1'b0;
            slot_tx       <= '1;
            mcu_rx        <= 1'b1;
        end else begin
            state         <= state_d;
            active_slot   <= active_d;
            pending       <= pending_d;
            idle_cnt      <= idle_cnt_d;
            tmo_cnt       <= tmo_cnt_d;
            switching     <= (state_d != ROUTE);
            drain_timeout <= timeout_d;
            slot_tx       <= slot_tx_d;
            mcu_rx        <= mcu_rx_d;
        end
    end

endmodule

// File: tb/tb_uart_slot_router.sv
// Randomised bench for uart_slot_router: a queue-based reference model of the
// routing/switchover rules is compared against the DUT every cycle.
module tb_uart_slot_router;

    localparam int AW = 4;
    localparam int NS = 4;
    localparam int SS = 2;
    localparam int G  = 8;
    localparam int T  = 32;

    localparam int M_ROUTE = 0;
    localparam int M_DRAIN = 1;
    localparam int M_PARK  = 2;

    typedef logic [NS-1:0] rx_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [AW-1:0] uart_slot_en = '0;
    logic          mcu_tx = 1'b1;
    logic          mcu_rx;
    logic [NS-1:0] slot_rx = '1;
    logic [NS-1:0] slot_tx;
    logic [AW-1:0] active_slot;
    logic          switching;
    logic          drain_timeout;

    int n_checks = 0;
    int n_errors = 0;

    uart_slot_router #(
        .UART_ADDRESS_WIDTH(AW), .NUM_SLOTS(NS), .SYNC_STAGES(SS),
        .GUARD_CYCLES(G), .DRAIN_TIMEOUT(T)
    ) dut (
        .clk(clk), .resetn(resetn), .uart_slot_en(uart_slot_en),
        .mcu_tx(mcu_tx), .mcu_rx(mcu_rx), .slot_rx(slot_rx), .slot_tx(slot_tx),
        .active_slot(active_slot), .switching(switching), .drain_timeout(drain_timeout)
    );

    always #5 clk = ~clk;

    // Reference model: input history queues stand in for the synchronisers.
    bit   tx_q[$];
    rx_t  rx_q[$];
    int   m_mode, m_active, m_pending, m_age, m_run, m_parked;
    rx_t  m_slot_tx;
    bit   m_mcu_rx, m_sw, m_dto;

    task automatic model_reset();
        tx_q = {};
        rx_q = {};
        for (int i = 0; i < SS; i++) begin
            tx_q.push_back(1'b1);
            rx_q.push_back('1);
        end
        m_mode = M_ROUTE; m_active = 0; m_pending = 0;
        m_age = 0; m_run = 0; m_parked = 0;
        m_slot_tx = '1; m_mcu_rx = 1'b1; m_sw = 1'b0; m_dto = 1'b0;
    endtask

    task automatic model_step();
        bit  tx_s, sel_rx, both, pulse;
        rx_t rx_s;
        int  sel;
        tx_s   = tx_q[0];
        rx_s   = rx_q[0];
        sel    = int'(uart_slot_en);
        sel_rx = (m_active < NS) ? rx_s[m_active] : 1'b1;
        both   = tx_s && sel_rx;
        pulse  = 1'b0;

        m_slot_tx = '1;
        m_mcu_rx  = 1'b1;
        if (m_mode != M_PARK && m_active < NS) begin
            m_slot_tx[m_active] = tx_s;
            m_mcu_rx = sel_rx;
        end

        if (m_mode == M_ROUTE) begin
            if (sel != m_active) begin
                m_pending = sel; m_age = 0; m_run = 0; m_mode = M_DRAIN;
            end
        end else if (m_mode == M_DRAIN) begin
            m_pending = sel;
            if (sel == m_active) begin
                m_mode = M_ROUTE;
            end else begin
                m_run = both ? m_run + 1 : 0;
                m_age++;
                if (both && m_run == G) begin
                    m_mode = M_PARK; m_parked = 0;
                end else if (m_age == T) begin
                    m_mode = M_PARK; m_parked = 0; pulse = 1'b1;
                end
            end
        end else begin
            m_parked++;
            if (m_parked == G) begin
                m_active = m_pending;
                m_mode = M_ROUTE;
            end
        end
        m_sw  = (m_mode != M_ROUTE);
        m_dto = pulse;

        tx_q.push_back(mcu_tx);
        void'(tx_q.pop_front());
        rx_q.push_back(slot_rx);
        void'(rx_q.pop_front());
    endtask

    always @(posedge clk) begin
        if (!resetn) model_reset();
        else         model_step();
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("slot_tx",       32'(slot_tx),       32'(m_slot_tx));
        check("mcu_rx",        32'(mcu_rx),        32'(m_mcu_rx));
        check("active_slot",   32'(active_slot),   32'(m_active));
        check("switching",     32'(switching),     32'(m_sw));
        check("drain_timeout", 32'(drain_timeout), 32'(m_dto));
    endtask

    // Runs one complete switchover; tx_low holds mcu_tx low for that many
    // cycles, tx_period (if nonzero) toggles it every tx_period cycles.
    task automatic run_switch(input int tx_low, input int tx_period,
                              output int sw, output int pulses);
        bit seen;
        seen = 1'b0; sw = 0; pulses = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (switching) begin sw++; seen = 1'b1; end
            if (drain_timeout) pulses++;
            if (tx_period > 0) mcu_tx = (((k + 1) / tx_period) % 2) != 0;
            else               mcu_tx = (k + 1 >= tx_low);
            if (seen && !switching) return;
        end
        check("switch_bound", 32'd0, 32'd1);
    endtask

    initial begin
        int sw, pulses;
        model_reset();

        repeat (3) tick();
        resetn = 1'b1;
        check("reset_active", 32'(active_slot), 32'd0);
        check("reset_switching", 32'(switching), 32'd0);
        check("reset_slot_tx", 32'(slot_tx), 32'hF);
        check("reset_mcu_rx", 32'(mcu_rx), 32'd1);

        // Plain routing to slot 0 with random line activity.
        for (int k = 0; k < 40; k++) begin
            tick();
            mcu_tx  = $urandom_range(1, 0);
            slot_rx = rx_t'($urandom);
        end
        mcu_tx = 1'b1; slot_rx = '1;
        repeat (4) tick();

        // Idle switch 0 -> 2: 8 DRAIN + 8 PARK cycles, no timeout.
        uart_slot_en = 4'd2;
        run_switch(0, 0, sw, pulses);
        check("idle_switch_cycles", 32'(sw), 32'd16);
        check("idle_switch_pulses", 32'(pulses), 32'd0);
        check("idle_switch_active", 32'(active_slot), 32'd2);

        // Switch to 1 mid-frame: mcu_tx low 12 cycles delays the idle window.
        uart_slot_en = 4'd1; mcu_tx = 1'b0;
        run_switch(12, 0, sw, pulses);
        check("midframe_cycles", 32'(sw), 32'd29);
        check("midframe_pulses", 32'(pulses), 32'd0);
        check("midframe_active", 32'(active_slot), 32'd1);

        // Switch to 3 with a busy line: forced by timeout after 32 DRAIN cycles.
        uart_slot_en = 4'd3; mcu_tx = 1'b0;
        run_switch(0, 4, sw, pulses);
        check("timeout_cycles", 32'(sw), 32'd40);
        check("timeout_pulses", 32'(pulses), 32'd1);
        check("timeout_active", 32'(active_slot), 32'd3);

        mcu_tx = 1'b1;
        uart_slot_en = 4'd0;
        run_switch(0, 0, sw, pulses);
        check("back_to_0", 32'(active_slot), 32'd0);

        // Brief request for slot 2 then back to 0: DRAIN aborts, no PARK.
        uart_slot_en = 4'd2;
        sw = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (switching) sw++;
            if (k == 1) uart_slot_en = 4'd0;
            mcu_tx = $urandom_range(1, 0);
        end
        check("abort_cycles", 32'(sw), 32'd2);
        check("abort_active", 32'(active_slot), 32'd0);
        mcu_tx = 1'b1;
        repeat (4) tick();

        // No-slot code: everything stays idle-high whatever the inputs do.
        uart_slot_en = 4'd15;
        run_switch(0, 0, sw, pulses);
        check("none_cycles", 32'(sw), 32'd16);
        check("none_active", 32'(active_slot), 32'd15);
        for (int k = 0; k < 30; k++) begin
            tick();
            check("none_slot_tx", 32'(slot_tx), 32'hF);
            check("none_mcu_rx", 32'(mcu_rx), 32'd1);
            mcu_tx  = $urandom_range(1, 0);
            slot_rx = rx_t'($urandom);
        end
        mcu_tx = 1'b1; slot_rx = '1;
        repeat (4) tick();

        // Reset in the middle of PARK.
        uart_slot_en = 4'd1;
        repeat (11) tick();
        check("in_park", 32'(switching), 32'd1);
        resetn = 1'b0;
        uart_slot_en = 4'd0;
        tick();
        check("park_reset_active", 32'(active_slot), 32'd0);
        check("park_reset_switching", 32'(switching), 32'd0);
        check("park_reset_slot_tx", 32'(slot_tx), 32'hF);
        check("park_reset_mcu_rx", 32'(mcu_rx), 32'd1);
        resetn = 1'b1;

        // Random traffic with occasional slot requests, including invalid codes.
        for (int k = 0; k < 3000; k++) begin
            tick();
            if ($urandom_range(59, 0) == 0) uart_slot_en = AW'($urandom_range(15, 0));
            if ($urandom_range(3, 0) == 0) mcu_tx = $urandom_range(1, 0);
            if ($urandom_range(3, 0) == 0) slot_rx = rx_t'($urandom) | rx_t'($urandom);
            if ($urandom_range(399, 0) == 0) resetn = 1'b0;
            else resetn = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
